lsm_mem_sequencer: RTL and testbench

// - Memory-side sequencer for ARM LDM/STM: from IR and base Rn, walks the register list lowest-first and

---
 rtl/lsm_mem_sequencer_pkg.sv | 31 +++
 rtl/lsm_prio_enc.sv | 21 ++
 rtl/lsm_mem_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_lsm_mem_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_mem_sequencer_pkg.sv
// Shared definitions for the LDM/STM memory-side sequencer.
//   - state_t      : FSM encoding, also driven out of the top for observability
//   - IR_*         : bit positions of the instruction fields used by the sequencer
//   - popcount16() : number of registers named in a 16-bit register list
package lsm_mem_sequencer_pkg;

  localparam int IR_P       = 24;  // pre (1) / post (0) indexing
  localparam int IR_U       = 23;  // up (1) / down (0)
  localparam int IR_W       = 21;  // base writeback
  localparam int IR_L       = 20;  // load (1) / store (0)
  localparam int IR_RN_LO   = 16;  // Rn occupies IR[19:16]
  localparam int IR_LIST_HI = 15;  // register list occupies IR[15:0]

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_ADV   = 3'd4,
    S_WB    = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder for a 16-entry register list.
//   i_list  : register list (bit n = register n)
//   o_idx   : index of the lowest set bit (0 when the list is empty)
//   o_valid : list contains at least one set bit
module lsm_prio_enc (
  input  logic [15:0] i_list,
  output logic [3:0]  o_idx,
  output logic        o_valid
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (i_list[i]) o_idx = 4'(i);
    end
  end

  assign o_valid = |i_list;

endmodule

// File: rtl/lsm_mem_sequencer.sv
// Memory-side sequencer for ARM LDM/STM. Captures IR and the base register on
// i_start, walks the register list lowest-first issuing one word transfer per
// set bit, and finally offers the Rn writeback value.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_start                : one-cycle request, honoured only in IDLE
//   i_ir, i_base           : instruction word and value of Rn, captured at start
//   i_moc                  : memory operation complete for the current beat
//   o_mem_en/rw/addr       : memory request (rw: 1 = read/LDM, 0 = write/STM)
//   o_reg_addr, o_reg_we   : register-file address and load strobe of the beat
//   o_wb_en, o_wb_value    : one-cycle Rn writeback strobe and value
//   o_busy, o_done         : operation in flight / one-cycle completion pulse
//   o_state                : current FSM state
//
// Memory handshake: o_mem_en is the request valid and i_moc the completion.
// Once o_mem_en rises (ISSUE) address, direction and register number stay
// constant until i_moc is seen high in WAIT; i_moc is ignored in every other
// state, so a completion that is already high during ISSUE is taken on the
// first WAIT cycle.
module lsm_mem_sequencer
  import lsm_mem_sequencer_pkg::*;
#(
  parameter int AW    = 32,
  parameter int WSTEP = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [31:0]   i_ir,
  input  logic [AW-1:0] i_base,
  input  logic          i_moc,
  output logic          o_mem_en,
  output logic          o_mem_rw,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_reg_addr,
  output logic          o_reg_we,
  output logic          o_wb_en,
  output logic [AW-1:0] o_wb_value,
  output logic          o_busy,
  output logic          o_done,
  output state_t        o_state
);

  state_t        r_state, w_state_nxt;
  logic          r_p, r_u, r_w, r_l;
  logic [3:0]    r_rn;
  logic [15:0]   r_list_orig;   // list as issued, used for the writeback check
  logic [15:0]   r_list;        // remaining registers, serviced bits cleared
  logic [4:0]    r_cnt;         // remaining beats
  logic [AW-1:0] r_addr;        // base until SETUP, then the current beat address
  logic [AW-1:0] r_wb_value;
  logic          r_adv_ph;      // second cycle of ADV

  logic [3:0]    w_idx;
  logic          w_idx_valid;
  logic [15:0]   w_bit;
  logic [4:0]    w_n;
  logic [AW-1:0] w_span;
  logic [AW-1:0] w_start_addr;
  logic [AW-1:0] w_wb_value;
  logic          w_unused_ir;

  assign w_unused_ir = ^{i_ir[31:25], i_ir[22]};

  lsm_prio_enc u_prio_enc (
    .i_list  (r_list),
    .o_idx   (w_idx),
    .o_valid (w_idx_valid)
  );

  assign w_bit  = 16'b1 << w_idx;
  assign w_n    = popcount16(r_list);
  assign w_span = AW'(w_n) * AW'(WSTEP);

  // r_addr still holds the base while in SETUP. Arithmetic wraps modulo 2^AW.
  always_comb begin
    w_start_addr = r_addr;
    unique case ({r_p, r_u})
      2'b01:   w_start_addr = r_addr;                          // IA
      2'b11:   w_start_addr = r_addr + AW'(WSTEP);             // IB
      2'b00:   w_start_addr = r_addr - w_span + AW'(WSTEP);    // DA
      default: w_start_addr = r_addr - w_span;                 // DB
    endcase
  end

  assign w_wb_value = r_u ? (r_addr + w_span) : (r_addr - w_span);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_p         <= 1'b0;
      r_u         <= 1'b0;
      r_w         <= 1'b0;
      r_l         <= 1'b0;
      r_rn        <= '0;
      r_list_orig <= '0;
      r_list      <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wb_value  <= '0;
      r_adv_ph    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_p         <= i_ir[IR_P];
            r_u         <= i_ir[IR_U];
            r_w         <= i_ir[IR_W];
            r_l         <= i_ir[IR_L];
            r_rn        <= i_ir[IR_RN_LO +: 4];
            r_list_orig <= i_ir[IR_LIST_HI:0];
            r_list      <= i_ir[IR_LIST_HI:0];
            r_addr      <= i_base;
          end
        end
        S_SETUP: begin
          r_cnt      <= w_n;
          r_addr     <= w_start_addr;
          r_wb_value <= w_wb_value;
        end
        S_ADV: begin
          // First cycle retires the beat; the second decides from the
          // registered count, keeping the decision off the clear/increment path.
          if (!r_adv_ph) begin
            r_list   <= r_list & ~w_bit;
            r_addr   <= r_addr + AW'(WSTEP);
            r_cnt    <= r_cnt - 5'd1;
            r_adv_ph <= 1'b1;
          end else begin
            r_adv_ph <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_mem_en    = 1'b0;
    o_mem_rw    = 1'b0;
    o_mem_addr  = '0;
    o_reg_addr  = '0;
    o_reg_we    = 1'b0;
    o_wb_en     = 1'b0;
    o_wb_value  = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        o_busy      = 1'b1;
        w_state_nxt = (w_n == 5'd0) ? S_FIN : S_ISSUE;
      end
      S_ISSUE: begin
        o_busy      = 1'b1;
        o_mem_en    = w_idx_valid;
        o_mem_rw    = r_l;
        o_mem_addr  = r_addr;
        o_reg_addr  = w_idx;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        o_busy     = 1'b1;
        o_mem_en   = w_idx_valid;
        o_mem_rw   = r_l;
        o_mem_addr = r_addr;
        o_reg_addr = w_idx;
        if (i_moc) begin
          o_reg_we    = r_l;
          w_state_nxt = S_ADV;
        end
      end
      S_ADV: begin
        o_busy = 1'b1;
        if (r_adv_ph) begin
          if (r_cnt == 5'd0) w_state_nxt = r_w ? S_WB : S_FIN;
          else               w_state_nxt = S_ISSUE;
        end
      end
      S_WB: begin
        o_busy = 1'b1;
        // A load into Rn itself beats the base writeback.
        o_wb_en     = ~(r_l & r_list_orig[r_rn]);
        o_wb_value  = r_wb_value;
        w_state_nxt = S_FIN;
      end
      S_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: tb/tb_lsm_mem_sequencer.sv
module tb_lsm_mem_sequencer;
  import lsm_mem_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_moc = 1'b0;
  logic [31:0] i_ir = '0;
  logic [31:0] i_base = '0;
  logic        o_mem_en, o_mem_rw, o_reg_we, o_wb_en, o_busy, o_done;
  logic [31:0] o_mem_addr, o_wb_value;
  logic [3:0]  o_reg_addr;
  state_t      o_state;

  always #5 clk = ~clk;

  lsm_mem_sequencer #(.AW(32), .WSTEP(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_ir       (i_ir),
    .i_base     (i_base),
    .i_moc      (i_moc),
    .o_mem_en   (o_mem_en),
    .o_mem_rw   (o_mem_rw),
    .o_mem_addr (o_mem_addr),
    .o_reg_addr (o_reg_addr),
    .o_reg_we   (o_reg_we),
    .o_wb_en    (o_wb_en),
    .o_wb_value (o_wb_value),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_state    (o_state)
  );

  // ---------------- observation record ----------------
  int          checks = 0;
  int          errors = 0;
  // beat = {mem_rw, reg_we, mem_addr, reg_addr}, taken in the cycle MOC is given
  logic [37:0] mon_beat[$];
  int          mon_done_cyc, mon_wb_cnt, mon_memen_cnt, mon_hold_err, mon_stray_we, mon_abort_ev;
  logic [31:0] mon_wb_val;
  logic        mon_busy1, mon_busy_done;
  logic [73:0] mon_rst_outs;

  // ---------------- driver + memory responder ----------------
  // Cycle 0 is the cycle START is high. Memory answers MOC in the second cycle
  // MEM_EN is high (first WAIT cycle), plus slow_delay extra cycles on beat
  // slow_beat. restart_cyc pulses a second START with a different IR;
  // reset_cyc pulls RST_N low for three cycles and abandons the operation.
  task automatic run_op(input logic [31:0] ir, input logic [31:0] base, input int slow_beat,
                        input int slow_delay, input int restart_cyc, input int reset_cyc);
    int          en_cnt;
    int          beat;
    int          need;
    logic [31:0] prev_addr;
    logic [3:0]  prev_reg;
    mon_beat.delete();
    mon_done_cyc = -1; mon_wb_cnt = 0; mon_wb_val = '0; mon_memen_cnt = 0;
    mon_hold_err = 0; mon_stray_we = 0; mon_abort_ev = 0;
    mon_busy1 = 1'b0; mon_busy_done = 1'b1; mon_rst_outs = '1;
    en_cnt = 0; beat = 0; prev_addr = '0; prev_reg = '0;
    @(negedge clk);
    i_start = 1'b1; i_ir = ir; i_base = base; i_moc = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      i_start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        i_ir = 32'hFFFF_FFFF; i_base = 32'hDEAD_0000;
      end
      if (cyc == reset_cyc) begin
        i_moc = 1'b0; i_rst_n = 1'b0; #1;
        mon_rst_outs = {o_mem_en, o_mem_rw, o_mem_addr, o_reg_addr, o_reg_we,
                        o_wb_en, o_wb_value, o_busy, o_done};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (o_done || o_wb_en || o_busy || o_mem_en) mon_abort_ev++;
        end
        i_rst_n = 1'b1;
        break;
      end
      if (o_mem_en) en_cnt++; else en_cnt = 0;
      need  = 2 + ((beat == slow_beat) ? slow_delay : 0);
      i_moc = o_mem_en && (en_cnt == need);
      #1;
      if (cyc == 1) mon_busy1 = o_busy;
      if (o_mem_en) begin
        mon_memen_cnt++;
        if (en_cnt > 1 && (o_mem_addr !== prev_addr || o_reg_addr !== prev_reg)) mon_hold_err++;
        prev_addr = o_mem_addr; prev_reg = o_reg_addr;
      end
      if (i_moc) begin
        mon_beat.push_back({o_mem_rw, o_reg_we, o_mem_addr, o_reg_addr});
        beat++;
      end else if (o_reg_we) begin
        mon_stray_we++;
      end
      if (o_wb_en) begin
        mon_wb_cnt++; mon_wb_val = o_wb_value;
      end
      if (o_done) begin
        mon_done_cyc = cyc; mon_busy_done = o_busy;
        break;
      end
    end
    i_start = 1'b0; i_moc = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_mem_en, o_mem_rw, o_mem_addr, o_reg_addr, o_reg_we, o_wb_en, o_wb_value, o_busy, o_done} !== 74'd0) begin
      errors++; $display("FAIL reset_outputs: got mem_en=%b addr=%h busy=%b done=%b expected all zero",
                         o_mem_en, o_mem_addr, o_busy, o_done);
    end
    checks++;
    if (o_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", o_state, S_IDLE);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // STM IA, Rn=R1, list {R0,R2}, W=1, BASE=0x100
  task automatic test_stm_ia();
    logic [37:0] exp_b [2];
    logic [37:0] got;
    exp_b[0] = {1'b0, 1'b0, 32'h0000_0100, 4'd0};
    exp_b[1] = {1'b0, 1'b0, 32'h0000_0104, 4'd2};
    run_op(32'h00A1_0005, 32'h0000_0100, -1, 0, -1, -1);
    checks++;
    if (mon_beat.size() != 2) begin errors++; $display("FAIL stm_ia_beats: got %0d expected 2", mon_beat.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < mon_beat.size()) ? mon_beat[i] : 'x;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL stm_ia_beat%0d: got %h expected %h", i, got, exp_b[i]); end
    end
    checks++;
    if (mon_wb_cnt != 1 || mon_wb_val !== 32'h0000_0108) begin
      errors++; $display("FAIL stm_ia_wb: got count %0d value %h expected 1 / 00000108", mon_wb_cnt, mon_wb_val);
    end
    checks++;
    if (mon_done_cyc != 11) begin errors++; $display("FAIL stm_ia_done_cycle: got %0d expected 11", mon_done_cyc); end
    checks++;
    if (mon_busy1 !== 1'b1 || mon_busy_done !== 1'b0) begin
      errors++; $display("FAIL stm_ia_busy: got first=%b at_done=%b expected 1/0", mon_busy1, mon_busy_done);
    end
  endtask

  // LDM DB, Rn=R5, list {R0,R1,R15}, W=0, BASE=0x200
  task automatic test_ldm_db();
    logic [37:0] exp_b [3];
    logic [37:0] got;
    exp_b[0] = {1'b1, 1'b1, 32'h0000_01F4, 4'd0};
    exp_b[1] = {1'b1, 1'b1, 32'h0000_01F8, 4'd1};
    exp_b[2] = {1'b1, 1'b1, 32'h0000_01FC, 4'd15};
    run_op(32'h0115_8003, 32'h0000_0200, -1, 0, -1, -1);
    checks++;
    if (mon_beat.size() != 3) begin errors++; $display("FAIL ldm_db_beats: got %0d expected 3", mon_beat.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_beat.size()) ? mon_beat[i] : 'x;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL ldm_db_beat%0d: got %h expected %h", i, got, exp_b[i]); end
    end
    checks++;
    if (mon_wb_cnt != 0 || mon_stray_we != 0) begin
      errors++; $display("FAIL ldm_db_wb_we: got wb %0d stray_we %0d expected 0/0", mon_wb_cnt, mon_stray_we);
    end
    checks++;
    if (mon_done_cyc != 14) begin errors++; $display("FAIL ldm_db_done_cycle: got %0d expected 14", mon_done_cyc); end
  endtask

  // Empty list with W=1
  task automatic test_empty_list();
    run_op(32'h00A2_0000, 32'h0000_0040, -1, 0, -1, -1);
    checks++;
    if (mon_done_cyc != 2) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 2", mon_done_cyc); end
    checks++;
    if (mon_memen_cnt != 0 || mon_wb_cnt != 0) begin
      errors++; $display("FAIL empty_activity: got mem_en %0d wb %0d expected 0/0", mon_memen_cnt, mon_wb_cnt);
    end
  endtask

  // LDM IA list {R0,R1,R2}; beat 2 completes 5 cycles late; START again mid-burst
  task automatic test_slow_moc();
    logic [37:0] exp_b [3];
    logic [37:0] got;
    exp_b[0] = {1'b1, 1'b1, 32'h0000_1000, 4'd0};
    exp_b[1] = {1'b1, 1'b1, 32'h0000_1004, 4'd1};
    exp_b[2] = {1'b1, 1'b1, 32'h0000_1008, 4'd2};
    run_op(32'h0094_0007, 32'h0000_1000, 1, 5, 8, -1);
    checks++;
    if (mon_beat.size() != 3) begin errors++; $display("FAIL slow_beats: got %0d expected 3", mon_beat.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < mon_beat.size()) ? mon_beat[i] : 'x;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL slow_beat%0d: got %h expected %h", i, got, exp_b[i]); end
    end
    checks++;
    if (mon_hold_err != 0) begin errors++; $display("FAIL slow_hold: got %0d changes expected 0", mon_hold_err); end
    checks++;
    if (mon_done_cyc != 19) begin errors++; $display("FAIL slow_done_cycle: got %0d expected 19", mon_done_cyc); end
  endtask

  // Reset during WAIT of beat 1 of 3, then a clean operation
  task automatic test_reset_abort();
    logic [37:0] exp_b [2];
    logic [37:0] got;
    exp_b[0] = {1'b0, 1'b0, 32'h0000_0100, 4'd0};
    exp_b[1] = {1'b0, 1'b0, 32'h0000_0104, 4'd2};
    run_op(32'h00A1_0007, 32'h0000_0300, 0, 10, -1, 3);
    checks++;
    if (mon_rst_outs !== 74'd0) begin errors++; $display("FAIL abort_outputs: got %h expected 0", mon_rst_outs); end
    checks++;
    if (mon_abort_ev != 0 || mon_done_cyc != -1 || mon_wb_cnt != 0) begin
      errors++; $display("FAIL abort_quiet: got events %0d done %0d wb %0d expected 0/-1/0",
                         mon_abort_ev, mon_done_cyc, mon_wb_cnt);
    end
    run_op(32'h00A1_0005, 32'h0000_0100, -1, 0, -1, -1);
    for (int i = 0; i < 2; i++) begin
      got = (i < mon_beat.size()) ? mon_beat[i] : 'x;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL after_abort_beat%0d: got %h expected %h", i, got, exp_b[i]); end
    end
    checks++;
    if (mon_done_cyc != 11 || mon_wb_val !== 32'h0000_0108) begin
      errors++; $display("FAIL after_abort_done: got cycle %0d wb %h expected 11 / 00000108", mon_done_cyc, mon_wb_val);
    end
  endtask

  // LDM IA with Rn=R3 inside list {R3,R4}, W=1: writeback suppressed
  task automatic test_wb_suppress();
    logic [37:0] got;
    run_op(32'h00B3_0018, 32'h0000_0080, -1, 0, -1, -1);
    got = (mon_beat.size() > 0) ? mon_beat[0] : 'x;
    checks++;
    if (got !== {1'b1, 1'b1, 32'h0000_0080, 4'd3}) begin
      errors++; $display("FAIL suppress_beat0: got %h expected %h", got, {1'b1, 1'b1, 32'h0000_0080, 4'd3});
    end
    checks++;
    if (mon_wb_cnt != 0 || mon_done_cyc != 11) begin
      errors++; $display("FAIL suppress_wb: got wb %0d done %0d expected 0/11", mon_wb_cnt, mon_done_cyc);
    end
  endtask

  // STM IB, list {R1}, W=1, BASE=0x10
  task automatic test_stm_ib();
    logic [37:0] got;
    run_op(32'h01A0_0002, 32'h0000_0010, -1, 0, -1, -1);
    got = (mon_beat.size() > 0) ? mon_beat[0] : 'x;
    checks++;
    if (got !== {1'b0, 1'b0, 32'h0000_0014, 4'd1}) begin
      errors++; $display("FAIL ib_beat0: got %h expected %h", got, {1'b0, 1'b0, 32'h0000_0014, 4'd1});
    end
    checks++;
    if (mon_wb_val !== 32'h0000_0014 || mon_done_cyc != 7) begin
      errors++; $display("FAIL ib_wb: got value %h done %0d expected 00000014/7", mon_wb_val, mon_done_cyc);
    end
  endtask

  // STM DA, all 16 registers, BASE=0x4: start address wraps below zero
  task automatic test_da_wrap();
    logic [37:0] got;
    run_op(32'h0026_FFFF, 32'h0000_0004, -1, 0, -1, -1);
    checks++;
    if (mon_beat.size() != 16) begin errors++; $display("FAIL da_beats: got %0d expected 16", mon_beat.size()); end
    got = (mon_beat.size() > 0) ? mon_beat[0] : 'x;
    checks++;
    if (got !== {1'b0, 1'b0, 32'hFFFF_FFC8, 4'd0}) begin
      errors++; $display("FAIL da_first: got %h expected %h", got, {1'b0, 1'b0, 32'hFFFF_FFC8, 4'd0});
    end
    got = (mon_beat.size() > 15) ? mon_beat[15] : 'x;
    checks++;
    if (got !== {1'b0, 1'b0, 32'h0000_0004, 4'd15}) begin
      errors++; $display("FAIL da_last: got %h expected %h", got, {1'b0, 1'b0, 32'h0000_0004, 4'd15});
    end
    checks++;
    if (mon_wb_val !== 32'hFFFF_FFC4 || mon_done_cyc != 67) begin
      errors++; $display("FAIL da_wb: got value %h done %0d expected FFFFFFC4/67", mon_wb_val, mon_done_cyc);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_empty_list();
    test_slow_moc();
    test_reset_abort();
    test_wb_suppress();
    test_stm_ib();
    test_da_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
